// File: rtl/spi_ram_cmd.sv
// Command-decoded single-port RAM behind the SPI slave, with independent write/read pointers
// and a RD_LAT-deep read pipeline. Define SPI_RAM_AUTOINC_EN for pointer auto-increment.
module spi_ram_cmd #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  localparam int PAY_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W,
  localparam int CMD_W = PAY_W + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CMD_W-1:0]  din,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid
);

  typedef enum logic [1:0] {
    OP_SET_WADDR = 2'b00,
    OP_WRITE     = 2'b01,
    OP_SET_RADDR = 2'b10,
    OP_READ      = 2'b11
  } opcode_t;

  localparam int DEPTH = 2 ** ADDR_W;

  generate
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
      $error("spi_ram_cmd: RD_LAT must be 1 or 2");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [RD_LAT-1:0] pipe_vld;
  logic [DATA_W-1:0] pipe_data [RD_LAT];

  opcode_t           op;
  logic [ADDR_W-1:0] pay_addr;
  logic [DATA_W-1:0] pay_data;
  logic              cmd_write;
  logic              cmd_read;

  assign op       = opcode_t'(din[CMD_W-1:CMD_W-2]);
  assign pay_addr = din[ADDR_W-1:0];
  assign pay_data = din[DATA_W-1:0];

  // Reset outranks any command presented on the same edge.
  assign cmd_write = rx_valid && !rst && (op == OP_WRITE);
  assign cmd_read  = rx_valid && !rst && (op == OP_READ);

  // Array is deliberately left out of reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (cmd_write) begin
      mem[wr_ptr] <= pay_data;
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_read) begin
      pipe_data[0] <= mem[rd_ptr];
    end
    for (int i = 1; i < RD_LAT; i++) begin
      if (pipe_vld[i-1]) begin
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pipe_vld <= '0;
      tx_valid <= 1'b0;
      dout     <= '0;
    end else begin
      if (rx_valid) begin
        unique case (op)
          OP_SET_WADDR: wr_ptr <= pay_addr;
          OP_WRITE: begin
`ifdef SPI_RAM_AUTOINC_EN
            wr_ptr <= wr_ptr + 1'b1;
`endif
          end
          OP_SET_RADDR: rd_ptr <= pay_addr;
          OP_READ: begin
`ifdef SPI_RAM_AUTOINC_EN
            rd_ptr <= rd_ptr + 1'b1;
`endif
          end
        endcase
      end

      pipe_vld[0] <= cmd_read;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end

      // The strobe comes only from the pipeline tail, never from the incoming command.
      tx_valid <= pipe_vld[RD_LAT-1];
      if (pipe_vld[RD_LAT-1]) begin
        dout <= pipe_data[RD_LAT-1];
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_cmd.sv
// Bench for spi_ram_cmd: RD_LAT=1 and RD_LAT=2 instances share one command stream and are
// checked against a queue-based model of outstanding reads keyed by due cycle.
module tb_spi_ram_cmd;

  localparam int CMD_W = 10;

`ifdef SPI_RAM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             rx_valid;
  logic [CMD_W-1:0] din;
  logic [7:0]       dout1;
  logic [7:0]       dout2;
  logic             tx_valid1;
  logic             tx_valid2;

  always #5 clk = ~clk;

  spi_ram_cmd #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .dout(dout1), .tx_valid(tx_valid1)
  );

  spi_ram_cmd #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .dout(dout2), .tx_valid(tx_valid2)
  );

  typedef struct {
    int         due;
    logic [7:0] data;
    bit         known;
  } rd_t;

  rd_t        q1[$];
  rd_t        q2[$];
  logic [7:0] m_mem [256];
  bit         m_known [256];
  logic [7:0] m_wptr;
  logic [7:0] m_rptr;
  int         cycle;

  bit         e_tx1, e_tx2;
  logic [7:0] e_dout1, e_dout2;
  bit         e_ok1, e_ok2;

  int vectors;
  int miscompares;

  // One clock of stimulus; the model advances by the command rules after the edge.
  task automatic step(input bit r, input bit v, input logic [1:0] op, input logic [7:0] pay);
    rd_t x;
    @(negedge clk);
    rst      = r;
    rx_valid = v;
    din      = {op, pay};
    @(posedge clk);
    cycle++;
    if (r) begin
      m_wptr = 8'h00;
      m_rptr = 8'h00;
      q1.delete();
      q2.delete();
      e_tx1 = 1'b0; e_tx2 = 1'b0;
      e_dout1 = 8'h00; e_dout2 = 8'h00;
      e_ok1 = 1'b1; e_ok2 = 1'b1;
    end else begin
      e_tx1 = 1'b0;
      e_tx2 = 1'b0;
      if (q1.size() > 0 && q1[0].due == cycle) begin
        x = q1.pop_front();
        e_tx1 = 1'b1; e_dout1 = x.data; e_ok1 = x.known;
      end
      if (q2.size() > 0 && q2[0].due == cycle) begin
        x = q2.pop_front();
        e_tx2 = 1'b1; e_dout2 = x.data; e_ok2 = x.known;
      end
      if (v) begin
        case (op)
          2'b00: m_wptr = pay;
          2'b01: begin
            m_mem[m_wptr]   = pay;
            m_known[m_wptr] = 1'b1;
            if (AUTOINC) m_wptr = m_wptr + 8'd1;
          end
          2'b10: m_rptr = pay;
          default: begin
            x.data  = m_mem[m_rptr];
            x.known = m_known[m_rptr];
            x.due   = cycle + 1;
            q1.push_back(x);
            x.due   = cycle + 2;
            q2.push_back(x);
            if (AUTOINC) m_rptr = m_rptr + 8'd1;
          end
        endcase
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 2'b11, 8'($urandom));
      vectors++;
      if (tx_valid1 !== 1'b0 || tx_valid2 !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_tx: got %b/%b expected 0/0", tx_valid1, tx_valid2);
      end
      vectors++;
      if (dout1 !== 8'h00 || dout2 !== 8'h00) begin
        miscompares++;
        $display("[TB] FAIL reset_dout: got %h/%h expected 00/00", dout1, dout2);
      end
    end
  endtask

  // Runs a command table (bit 10 = rx_valid) through both instances against the model.
  task automatic run_table(input string tag, input logic [10:0] seq[$]);
    for (int i = 0; i < seq.size(); i++) begin
      step(1'b0, seq[i][10], seq[i][9:8], seq[i][7:0]);
      vectors++;
      if (tx_valid1 !== e_tx1) begin
        miscompares++;
        $display("[TB] FAIL %s tx_valid lat1 step %0d: got %b expected %b", tag, i, tx_valid1, e_tx1);
      end
      vectors++;
      if (tx_valid2 !== e_tx2) begin
        miscompares++;
        $display("[TB] FAIL %s tx_valid lat2 step %0d: got %b expected %b", tag, i, tx_valid2, e_tx2);
      end
      if (e_ok1) begin
        vectors++;
        if (dout1 !== e_dout1) begin
          miscompares++;
          $display("[TB] FAIL %s dout lat1 step %0d: got %h expected %h", tag, i, dout1, e_dout1);
        end
      end
      if (e_ok2) begin
        vectors++;
        if (dout2 !== e_dout2) begin
          miscompares++;
          $display("[TB] FAIL %s dout lat2 step %0d: got %h expected %h", tag, i, dout2, e_dout2);
        end
      end
    end
  endtask

  task automatic test_read_zero();
    logic [10:0] seq[$];
    seq = '{11'h400, 11'h55A, 11'h600, 11'h700, 11'h000, 11'h000, 11'h000};
    run_table("read_zero", seq);
  endtask

  task automatic test_addr_10();
    logic [10:0] seq[$];
    seq = '{11'h410, 11'h5A5, 11'h610, 11'h700, 11'h000, 11'h000, 11'h000, 11'h000};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, seq[i][10], seq[i][9:8], seq[i][7:0]);
    end
    vectors++;
    if (tx_valid1 !== 1'b1 || dout1 !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL addr_10 strobe lat1: got %b/%h expected 1/a5", tx_valid1, dout1);
    end
    seq = '{11'h000, 11'h000, 11'h000};
    run_table("addr_10_hold", seq);
    vectors++;
    if (tx_valid1 !== 1'b0 || dout1 !== 8'hA5 || dout2 !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL addr_10 hold: got %b/%h/%h expected 0/a5/a5", tx_valid1, dout1, dout2);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] seq[$];
    seq = '{11'h401, 11'h511, 11'h402, 11'h522, 11'h403, 11'h533,
            11'h601, 11'h700, 11'h700, 11'h700, 11'h000, 11'h000, 11'h000};
    run_table("back_to_back", seq);
  endtask

  task automatic test_wrap();
    logic [10:0] seq[$];
    seq = '{11'h4FF, 11'h5C3, 11'h53C, 11'h6FF, 11'h700, 11'h000, 11'h000,
            11'h600, 11'h700, 11'h000, 11'h000};
    run_table("wrap", seq);
  endtask

  task automatic test_reset_midflight();
    logic [10:0] seq[$];
    seq = '{11'h610, 11'h700};
    run_table("midflight_pre", seq);
    step(1'b1, 1'b0, 2'b00, 8'h00);
    seq = '{11'h000, 11'h000, 11'h000};
    run_table("midflight_post", seq);
    vectors++;
    if (tx_valid2 !== 1'b0 || dout2 !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL midflight_drop: got %b/%h expected 0/00", tx_valid2, dout2);
    end
    seq = '{11'h700, 11'h000, 11'h000, 11'h610, 11'h700, 11'h000, 11'h000};
    run_table("midflight_intact", seq);
  endtask

  task automatic test_idle_rx();
    logic [10:0] seq[$];
    seq = '{11'h620, 11'h420, 11'h577};
    run_table("idle_setup", seq);
    seq.delete();
    for (int i = 0; i < 10; i++) seq.push_back({1'b0, 2'b11, 8'($urandom)});
    run_table("idle_rx", seq);
    seq = '{11'h700, 11'h000, 11'h000};
    run_table("idle_after", seq);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), 8'($urandom));
      vectors++;
      if (tx_valid1 !== e_tx1 || tx_valid2 !== e_tx2) begin
        miscompares++;
        $display("[TB] FAIL random tx step %0d: got %b/%b expected %b/%b",
                 i, tx_valid1, tx_valid2, e_tx1, e_tx2);
      end
      if (e_ok1) begin
        vectors++;
        if (dout1 !== e_dout1) begin
          miscompares++;
          $display("[TB] FAIL random dout lat1 step %0d: got %h expected %h", i, dout1, e_dout1);
        end
      end
      if (e_ok2) begin
        vectors++;
        if (dout2 !== e_dout2) begin
          miscompares++;
          $display("[TB] FAIL random dout lat2 step %0d: got %h expected %h", i, dout2, e_dout2);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cycle       = 0;
    rst         = 1'b1;
    rx_valid    = 1'b0;
    din         = '0;
    e_ok1       = 1'b0;
    e_ok2       = 1'b0;
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;

    test_reset();
    test_read_zero();
    test_addr_10();
    test_back_to_back();
    test_wrap();
    test_reset_midflight();
    test_idle_rx();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
